// File: rtl/debug_frame_collector_pkg.sv
// Shared definitions for the debug frame collector: header layout, frame type
// codes, FSM state encoding and a header unpack helper.
package debug_frame_collector_pkg;

  localparam logic [7:0] DEBUG_FRAME_SYNC = 8'hA5;

  localparam int HDR_TYPE_LSB  = 0;
  localparam int HDR_CYCLE_LSB = 8;
  localparam int HDR_COUNT_LSB = 16;
  localparam int HDR_SYNC_LSB  = 24;

  localparam logic [7:0] FRAME_REG_DUMP = 8'h01;
  localparam logic [7:0] FRAME_MEM_DUMP = 8'h02;
  localparam logic [7:0] FRAME_STATUS   = 8'h03;

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_DECODE = 3'd1,
    S_DATA   = 3'd2,
    S_EMIT   = 3'd3,
    S_END    = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] count;
    logic [7:0] cycle;
    logic [7:0] ftype;
  } frame_hdr_t;

  function automatic frame_hdr_t hdr_unpack(input logic [31:0] w);
    frame_hdr_t h;
    h.ftype = w[HDR_TYPE_LSB  +: 8];
    h.cycle = w[HDR_CYCLE_LSB +: 8];
    h.count = w[HDR_COUNT_LSB +: 8];
    h.sync  = w[HDR_SYNC_LSB  +: 8];
    return h;
  endfunction

endpackage

// File: rtl/debug_frame_collector_if.sv
// Payload word stream leaving the collector.
interface debug_frame_collector_if #(
  parameter int WORD_SIZE = 32
);
  // valid/ready: a word transfers on every clock where word_valid and word_ready
  // are both high; once word_valid rises, word and word_index hold steady and
  // word_valid stays high until that transfer happens.
  logic                 word_valid;
  logic                 word_ready;
  logic [WORD_SIZE-1:0] word;
  logic [7:0]           word_index;

  modport master (
    output word_valid,
    output word,
    output word_index,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word,
    input  word_index,
    output word_ready
  );
endinterface

// File: rtl/debug_frame_collector_byte_word_assembler.sv
// LSB-first byte-to-word shift assembler with a byte counter that can be
// preloaded to keep the current window for byte-slip resynchronisation.
module debug_frame_collector_byte_word_assembler #(
  parameter int UART_BUS_SIZE = 8,
  parameter int WORD_SIZE     = 32,
  localparam int BYTES        = WORD_SIZE / UART_BUS_SIZE,
  localparam int CNT_W        = $clog2(BYTES + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push_i,
  input  logic [UART_BUS_SIZE-1:0] byte_i,
  input  logic                     clear_i,
  input  logic                     preload_i,
  output logic [WORD_SIZE-1:0]     word_o,
  output logic [WORD_SIZE-1:0]     word_next_o,
  output logic                     last_byte_o
);

  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] shifted;

  // New bytes enter at the top so the first byte of a word ends up at bit 0.
  assign shifted     = {byte_i, shift_q[WORD_SIZE-1:UART_BUS_SIZE]};
  assign word_o      = shift_q;
  assign word_next_o = shifted;
  assign last_byte_o = push_i && (cnt_q == CNT_W'(BYTES - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (preload_i) begin
      cnt_d = CNT_W'(BYTES - 1);
    end else if (push_i) begin
      shift_d = shifted;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_frame_collector.sv
// Reassembles the debugger's UART byte stream into frames: checks the header
// sync byte (sliding one byte on mismatch) and emits payload words.
module debug_frame_collector
  import debug_frame_collector_pkg::*;
#(
  parameter int         UART_BUS_SIZE = 8,
  parameter int         WORD_SIZE     = 32,
  parameter logic [7:0] SYNC_BYTE     = DEBUG_FRAME_SYNC
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_fifo_empty,
  input  logic [UART_BUS_SIZE-1:0] i_fifo_data,
  output logic                     o_fifo_rd,
  debug_frame_collector_if.master  word_if,
  output logic [7:0]               o_frame_type,
  output logic [7:0]               o_frame_cycle,
  output logic                     o_frame_start,
  output logic                     o_frame_end,
  output logic                     o_sync_error,
  output logic [2:0]               o_state
);

  state_e               state_q;
  logic                 word_valid_q;
  logic [WORD_SIZE-1:0] word_q;
  logic [7:0]           index_q;
  logic [7:0]           count_q;
  logic [7:0]           type_q;
  logic [7:0]           cycle_q;
  logic                 start_q;
  logic                 end_q;
  logic                 sync_err_q;

  logic [WORD_SIZE-1:0] asm_word;
  logic [WORD_SIZE-1:0] asm_word_next;
  logic                 asm_last;
  logic                 asm_clear;
  logic                 asm_preload;
  logic                 collecting;
  logic                 accept;
  logic                 sync_ok;
  frame_hdr_t           hdr;

  assign hdr        = hdr_unpack(asm_word[31:0]);
  assign sync_ok    = (hdr.sync == SYNC_BYTE);
  assign collecting = (state_q == S_HDR) || (state_q == S_DATA);
  assign accept     = word_valid_q && word_if.word_ready;

  // FIFO is first-word-fall-through, so the pop and the byte capture share a cycle.
  assign o_fifo_rd = collecting && !i_fifo_empty && !i_reset;

  assign asm_clear   = ((state_q == S_DECODE) && sync_ok) ||
                       ((state_q == S_EMIT) && accept) ||
                       (state_q == S_END);
  assign asm_preload = (state_q == S_DECODE) && !sync_ok;

  debug_frame_collector_byte_word_assembler #(
    .UART_BUS_SIZE (UART_BUS_SIZE),
    .WORD_SIZE     (WORD_SIZE)
  ) u_asm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .push_i      (o_fifo_rd),
    .byte_i      (i_fifo_data),
    .clear_i     (asm_clear),
    .preload_i   (asm_preload),
    .word_o      (asm_word),
    .word_next_o (asm_word_next),
    .last_byte_o (asm_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_HDR;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      index_q      <= '0;
      count_q      <= '0;
      type_q       <= '0;
      cycle_q      <= '0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      sync_err_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (asm_last) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (sync_ok) begin
            type_q  <= hdr.ftype;
            cycle_q <= hdr.cycle;
            count_q <= hdr.count;
            index_q <= '0;
            start_q <= 1'b1;
            state_q <= (hdr.count == 8'd0) ? S_END : S_DATA;
          end else begin
            // Window is kept; the next byte slides it by one and re-checks.
            sync_err_q <= 1'b1;
            state_q    <= S_HDR;
          end
        end
        S_DATA: begin
          if (asm_last) begin
            word_q       <= asm_word_next;
            word_valid_q <= 1'b1;
            state_q      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (accept) begin
            word_valid_q <= 1'b0;
            if (index_q == count_q - 8'd1) begin
              state_q <= S_END;
            end else begin
              index_q <= index_q + 8'd1;
              state_q <= S_DATA;
            end
          end
        end
        S_END: begin
          end_q   <= 1'b1;
          state_q <= S_HDR;
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign word_if.word_valid = word_valid_q;
  assign word_if.word       = word_q;
  assign word_if.word_index = index_q;
  assign o_frame_type       = type_q;
  assign o_frame_cycle      = cycle_q;
  assign o_frame_start      = start_q;
  assign o_frame_end        = end_q;
  assign o_sync_error       = sync_err_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_debug_frame_collector.sv
// Bench for debug_frame_collector: FIFO model feeding byte streams, a
// frame-level reference model, and an event scoreboard with latency checks.
`timescale 1ns/1ps
module tb_debug_frame_collector;
  import debug_frame_collector_pkg::*;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_fifo_empty = 1'b1;
  logic [7:0] i_fifo_data = 8'h00;
  logic       o_fifo_rd;
  logic [7:0] o_frame_type, o_frame_cycle;
  logic       o_frame_start, o_frame_end, o_sync_error;
  logic [2:0] o_state;

  debug_frame_collector_if #(.WORD_SIZE(32)) word_if ();

  always #5 i_clk = ~i_clk;

  debug_frame_collector dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_data   (i_fifo_data),
    .o_fifo_rd     (o_fifo_rd),
    .word_if       (word_if),
    .o_frame_type  (o_frame_type),
    .o_frame_cycle (o_frame_cycle),
    .o_frame_start (o_frame_start),
    .o_frame_end   (o_frame_end),
    .o_sync_error  (o_sync_error),
    .o_state       (o_state)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_idx_q[$];
  int          exp_wend_q[$];
  logic [15:0] exp_hdr_q[$];
  int          exp_hend_q[$];
  int          pop_cyc[$];
  logic [31:0] obs_log[$];
  logic [31:0] log_a[$];

  int exp_starts, exp_ends, exp_errs, exp_words;
  int seen_starts, seen_ends, seen_errs, seen_words;
  int cyc = 0;
  bit mon_en = 0, gap_en = 0, popped_last = 0, pending = 0;
  int rmode = 0, stall_left = 0, stall_level = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pop_at(input int p);
    if (p >= 0 && p < pop_cyc.size()) return pop_cyc[p];
    return -100;
  endfunction

  // ---------------- reference model ----------------
  // Slides a 4-byte window over the stream: a window whose last byte is not
  // the sync value is one sync error and advances by one byte; a good header
  // is followed by 'count' little-endian words. Only complete items are expected.
  task automatic model_build();
    int pos, n, cnt, k;
    logic [31:0] w;
    exp_q.delete(); exp_idx_q.delete(); exp_wend_q.delete();
    exp_hdr_q.delete(); exp_hend_q.delete();
    exp_starts = 0; exp_ends = 0; exp_errs = 0; exp_words = 0;
    pos = 0;
    n = stim_q.size();
    while (pos + 3 < n) begin
      if (stim_q[pos+3] != DEBUG_FRAME_SYNC) begin
        exp_errs++;
        pos++;
      end else begin
        cnt = int'(stim_q[pos+2]);
        exp_hdr_q.push_back({stim_q[pos+1], stim_q[pos]});
        exp_hend_q.push_back(pos + 3);
        exp_starts++;
        pos += 4;
        k = 0;
        while (k < cnt && pos + 3 < n) begin
          w = {stim_q[pos+3], stim_q[pos+2], stim_q[pos+1], stim_q[pos]};
          exp_q.push_back(w);
          exp_idx_q.push_back(8'(k));
          exp_wend_q.push_back(pos + 3);
          exp_words++;
          pos += 4;
          k++;
        end
        if (k == cnt) exp_ends++;
        else pos = n;
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic monitor();
    logic [15:0] h;
    if (o_fifo_rd) check_eq("pop_when_empty", i_fifo_empty, 0);
    if (word_if.word_valid) begin
      check_eq("pop_in_emit", o_fifo_rd, 0);
      check_eq("state_emit", o_state, 3);
      if (exp_q.size() == 0) begin
        check_eq("word_unexpected", exp_q.size(), 1);
      end else begin
        check_eq("word", word_if.word, exp_q[0]);
        check_eq("word_index", word_if.word_index, exp_idx_q[0]);
        if (!pending) check_eq("word_latency", cyc, pop_at(exp_wend_q[0]) + 1);
        if (word_if.word_ready) begin
          obs_log.push_back(word_if.word);
          void'(exp_q.pop_front());
          void'(exp_idx_q.pop_front());
          void'(exp_wend_q.pop_front());
          seen_words++;
        end
      end
      pending = !word_if.word_ready;
    end else begin
      pending = 0;
    end
    if (o_frame_start) begin
      seen_starts++;
      if (exp_hdr_q.size() == 0) begin
        check_eq("start_unexpected", exp_hdr_q.size(), 1);
      end else begin
        h = exp_hdr_q[0];
        check_eq("frame_type", o_frame_type, h[7:0]);
        check_eq("frame_cycle", o_frame_cycle, h[15:8]);
        check_eq("start_latency", cyc, pop_at(exp_hend_q[0]) + 2);
        void'(exp_hdr_q.pop_front());
        void'(exp_hend_q.pop_front());
      end
    end
    if (o_frame_end) seen_ends++;
    if (o_sync_error) seen_errs++;
  endtask

  // ---------------- FIFO / consumer driver ----------------
  always @(negedge i_clk) begin
    cyc++;
    if (fifo_q.size() != 0 && !(gap_en && (popped_last || $urandom_range(0, 2) == 0))) begin
      i_fifo_empty = 1'b0;
      i_fifo_data  = fifo_q[0];
    end else begin
      i_fifo_empty = 1'b1;
      i_fifo_data  = 8'($urandom_range(0, 255));
    end
    case (rmode)
      1: word_if.word_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (word_if.word_valid && stall_left > 0) begin
          word_if.word_ready = 1'b0;
          stall_left--;
        end else begin
          word_if.word_ready = 1'b1;
        end
      end
      default: word_if.word_ready = 1'b1;
    endcase
    #1;
    if (rmode == 2 && word_if.word_valid && !word_if.word_ready) begin
      if (stall_level < 0) stall_level = fifo_q.size();
      else check_eq("stall_fifo_level", fifo_q.size(), stall_level);
    end
    if (mon_en) monitor();
    popped_last = o_fifo_rd && !i_fifo_empty;
    if (popped_last) begin
      void'(fifo_q.pop_front());
      pop_cyc.push_back(cyc);
    end
  end

  // ---------------- segment runner ----------------
  task automatic run_segment(input bit gap, input int rm, input bit expect_idle, input string name);
    int t;
    model_build();
    seen_starts = 0; seen_ends = 0; seen_errs = 0; seen_words = 0;
    pop_cyc.delete(); obs_log.delete();
    pending = 0;
    stall_left = (rm == 2) ? 10 : 0;
    stall_level = -1;
    @(posedge i_clk);
    gap_en = gap;
    rmode  = rm;
    mon_en = 1;
    foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
    t = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || exp_hdr_q.size() != 0) && t < 4000) begin
      @(posedge i_clk);
      t++;
    end
    check_eq({name, "_timeout"}, t < 4000, 1);
    repeat (8) @(posedge i_clk);
    @(negedge i_clk); #2;
    check_eq({name, "_starts"}, seen_starts, exp_starts);
    check_eq({name, "_ends"}, seen_ends, exp_ends);
    check_eq({name, "_sync_errs"}, seen_errs, exp_errs);
    check_eq({name, "_words"}, seen_words, exp_words);
    if (expect_idle) begin
      check_eq({name, "_idle_state"}, o_state, 0);
      check_eq({name, "_idle_valid"}, word_if.word_valid, 0);
    end
    if (rm == 2) check_eq({name, "_stall_done"}, stall_left, 0);
    mon_en = 0;
    gap_en = 0;
    rmode  = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_valid"}, word_if.word_valid, 0);
    check_eq({name, "_word"}, word_if.word, 0);
    check_eq({name, "_index"}, word_if.word_index, 0);
    check_eq({name, "_type"}, o_frame_type, 0);
    check_eq({name, "_cycle"}, o_frame_cycle, 0);
    check_eq({name, "_start"}, o_frame_start, 0);
    check_eq({name, "_end"}, o_frame_end, 0);
    check_eq({name, "_sync_err"}, o_sync_error, 0);
    check_eq({name, "_fifo_rd"}, o_fifo_rd, 0);
    check_eq({name, "_state"}, o_state, 0);
  endtask

  task automatic push_words(input int nwords);
    for (int i = 0; i < 4 * nwords; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] types[3];
    int junk, cnt;
    types = '{FRAME_REG_DUMP, FRAME_MEM_DUMP, FRAME_STATUS};
    word_if.word_ready = 1'b1;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #2;
    check_reset_outputs("reset");
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);

    // Two-word register dump
    stim_q = '{8'h01, 8'h07, 8'h02, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88};
    run_segment(0, 0, 1, "basic");
    check_eq("basic_w0", (obs_log.size() > 0) ? obs_log[0] : 32'hX, 32'h44332211);
    check_eq("basic_w1", (obs_log.size() > 1) ? obs_log[1] : 32'hX, 32'h88776655);
    check_eq("basic_type_held", o_frame_type, 8'h01);
    check_eq("basic_cycle_held", o_frame_cycle, 8'h07);

    // Empty frame: start and end, no words
    stim_q = '{8'h03, 8'h09, 8'h00, 8'hA5};
    run_segment(0, 0, 1, "empty");
    check_eq("empty_no_words", seen_words, 0);
    check_eq("empty_end_once", seen_ends, 1);

    // One junk byte ahead of the header: single sync error, then recovery
    stim_q = '{8'h00, 8'h01, 8'h07, 8'h01, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_segment(0, 0, 1, "slip");
    check_eq("slip_err_once", seen_errs, 1);
    check_eq("slip_word", (obs_log.size() > 0) ? obs_log[0] : 32'hX, 32'hEFBEADDE);

    // Consumer stalls for 10 cycles on the first word
    stim_q = '{8'h02, 8'h11, 8'h02, 8'hA5};
    push_words(2);
    run_segment(0, 2, 1, "stall");

    // Same 3-word frame without and with FIFO gaps
    stim_q = '{8'h02, 8'h33, 8'h03, 8'hA5};
    push_words(3);
    run_segment(0, 0, 1, "nogap");
    log_a = obs_log;
    run_segment(1, 0, 1, "gap");
    check_eq("gap_log_size", obs_log.size(), log_a.size());
    foreach (log_a[i]) if (i < obs_log.size()) check_eq("gap_same_word", obs_log[i], log_a[i]);

    // Random frames with junk prefixes, random gaps and random backpressure
    stim_q.delete();
    for (int f = 0; f < 16; f++) begin
      junk = $urandom_range(0, 2);
      cnt  = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) stim_q.push_back(8'($urandom_range(0, 8'hA4)));
      stim_q.push_back(types[$urandom_range(0, 2)]);
      stim_q.push_back(8'($urandom_range(0, 8'hA4)));
      stim_q.push_back(8'(cnt));
      stim_q.push_back(DEBUG_FRAME_SYNC);
      push_words(cnt);
    end
    run_segment(1, 1, 1, "random");

    // Reset after two payload bytes, then a clean frame
    stim_q = '{8'h01, 8'h07, 8'h02, 8'hA5, 8'h11, 8'h22};
    run_segment(0, 0, 0, "partial");
    check_eq("partial_state_data", o_state, 2);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #2;
    check_reset_outputs("midreset");
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    check_eq("midreset_no_end", seen_ends, 0);
    stim_q = '{8'h02, 8'h44, 8'h01, 8'hA5, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_segment(0, 0, 1, "after_reset");
    check_eq("after_reset_word", (obs_log.size() > 0) ? obs_log[0] : 32'hX, 32'hBEBAFECA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_frame_collector.md
Name: debug_frame_collector

Overview:
- Host-side/loopback receiver for the debugger's outgoing UART byte stream.
- Pops bytes from an RX FIFO and reassembles them LSB-first into WORD_SIZE words.
- Validates the frame header and emits payload words (register or memory dump entries) on a valid/ready interface.
- Used for in-FPGA self-test of the debugger (TX looped back to RX) and on the companion capture board.

Parameters:
- UART_BUS_SIZE, 8, FIFO byte width.
- WORD_SIZE, 32, reassembled word width; integer multiple of UART_BUS_SIZE and >= 32.
- SYNC_BYTE, 8'hA5, required value of header bits [31:24].

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_fifo_empty  in  1  RX FIFO empty
- i_fifo_data  in  UART_BUS_SIZE  RX FIFO head byte (first-word-fall-through)
- o_fifo_rd  out  1  pop strobe; byte sampled the same cycle
- o_word_valid  out  1  payload word available
- i_word_ready  in  1  consumer accepts word
- o_word  out  WORD_SIZE  payload word
- o_word_index  out  8  index of o_word within frame, 0-based
- o_frame_type  out  8  latched header type
- o_frame_cycle  out  8  latched header clock-cycle count
- o_frame_start  out  1  one-cycle pulse when a valid header is decoded
- o_frame_end  out  1  one-cycle pulse after the last payload word is accepted
- o_sync_error  out  1  one-cycle pulse on header sync mismatch
- o_state  out  3  current FSM state, for debug

Behaviour:
- Reset is i_reset, synchronous, active-high; clock is i_clk. Reset values: all outputs 0, state S_HDR, counters 0. Reset mid-frame discards the partial frame; no o_frame_end is issued.
- Byte read: in S_HDR or S_DATA with !i_fifo_empty, drive o_fifo_rd=1 and capture i_fifo_data the same cycle. At most 1 byte per cycle. Never pop when empty.
- Assembly: shift register; each byte enters at the MSB and the register shifts right by UART_BUS_SIZE. After BYTES=WORD_SIZE/UART_BUS_SIZE bytes, byte k occupies bits [8k+7:8k].
- Header word fields: [7:0] type, [15:8] cycle, [23:16] count (payload words, 0..255), [31:24] sync.
- State S_HDR (0): collect bytes until the byte counter reaches BYTES, then go to S_DECODE.
- State S_DECODE (1), one cycle, no pop:
  - sync==SYNC_BYTE: latch type, cycle and count; pulse o_frame_start; clear index; go to S_END if count==0, else S_DATA.
  - Mismatch: pulse o_sync_error; set byte counter to BYTES-1 (keep the window); go to S_HDR. The next byte slides the window by one byte and the header is re-checked (byte-slip resync).
- State S_DATA (2): collect BYTES bytes into a cleared assembler, then go to S_EMIT.
- State S_EMIT (3): o_word_valid=1; o_word and o_word_index held stable. On valid&&ready: if index==count-1 go to S_END, else increment index and go to S_DATA. No FIFO pop while in S_EMIT (backpressure).
- State S_END (4): pulse o_frame_end for one cycle, then go to S_HDR with a cleared assembler.
- Latency: last header byte -> o_frame_start is 2 cycles; last payload byte -> o_word_valid is 1 cycle.
- o_frame_type and o_frame_cycle hold until the next valid header.
- FIFO empty mid-word: wait indefinitely; partial bytes are retained.

Decomposition:
- Shared package debugger.vh gains:
  - DEBUG_FRAME_SYNC
  - header field offsets: TYPE [7:0], CYCLE [15:8], COUNT [23:16], SYNC [31:24]
  - frame type codes: REG_DUMP=8'h01, MEM_DUMP=8'h02, STATUS=8'h03
  - state encodings
- One sub-module: byte_word_assembler (shift register, byte counter, preload for resync).

Test Plan:
- Header bytes 01,07,02,A5 then 11,22,33,44 and 55,66,77,88 with ready=1: o_frame_start pulse, type=01, cycle=07; words 0x44332211 (idx 0) and 0x88776655 (idx 1); one o_frame_end.
- Header 03,09,00,A5: o_frame_start then o_frame_end with no o_word_valid.
- Bytes 00 followed by header 01,07,01,A5 and 1 word: o_sync_error exactly once; frame recovered after a 1-byte slip.
- i_word_ready=0 for 10 cycles during S_EMIT: o_word stable, no o_fifo_rd, FIFO level unchanged.
- FIFO empty gaps between every byte of a 3-word frame: identical words to the gapless run.
- i_reset asserted after 2 payload bytes: all outputs 0, state 0; next clean frame decodes correctly.
